param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_if.sv | 22 ++
 rtl/param_fifo.sv | 112 +++++++++++
 tb/tb_param_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// Producer/consumer handshake bundle for param_fifo.
// The FIFO sits on the slave side; the producer and consumer drive the master side.
interface param_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] enq_data;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] deq_data;
    logic              deq_valid;
    logic              deq_ready;

    modport master (
        output enq_data, enq_valid, deq_ready,
        input  enq_ready, deq_data, deq_valid
    );

    modport slave (
        input  enq_data, enq_valid, deq_ready,
        output enq_ready, deq_data, deq_valid
    );
endinterface

// File: rtl/param_fifo.sv
// Parameterised FIFO with any-depth storage and an optional registered output stage.
// It also provides level flags, a high-water mark and a sticky overflow flag.
module param_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int FWFT   = 1,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    param_fifo_if.slave                bus,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] max_count,
    output logic                       overflow
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count, r_max, w_count_nxt;
    logic              r_ovf;
    logic              w_enq, w_deq, w_mem_rd;

    function automatic logic [PW-1:0] f_adv(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full          = (r_count == CW'(DEPTH));
    assign empty         = (r_count == '0);
    assign almost_full   = (32'(r_count) >= AF_TH);
    assign almost_empty  = (32'(r_count) <= AE_TH);
    assign count         = r_count;
    assign max_count     = r_max;
    assign overflow      = r_ovf;
    assign bus.enq_ready = !full && !flush;

    assign w_enq = bus.enq_valid && bus.enq_ready;
    assign w_deq = bus.deq_valid && bus.deq_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= bus.enq_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_enq)               r_wr_ptr <= f_adv(r_wr_ptr);
            if (w_mem_rd)            r_rd_ptr <= f_adv(r_rd_ptr);
            r_count <= w_count_nxt;
            if (w_count_nxt > r_max) r_max    <= w_count_nxt;
            if (bus.enq_valid && full) r_ovf  <= 1'b1;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.deq_valid = !empty;
        assign bus.deq_data  = r_mem[r_rd_ptr];
        assign w_mem_rd      = w_deq;
    end else begin : g_reg
        logic              r_out_vld;
        logic [DATA_W-1:0] r_out_data;
        logic [CW-1:0]     w_mem_cnt;

        // The output register holds the oldest word; storage only holds the words behind it.
        assign w_mem_cnt     = r_count - CW'(r_out_vld);
        assign w_mem_rd      = (w_mem_cnt != '0) && (!r_out_vld || w_deq);
        assign bus.deq_valid = r_out_vld;
        assign bus.deq_data  = r_out_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_vld  <= 1'b0;
                r_out_data <= '0;
            end else if (flush) begin
                r_out_vld  <= 1'b0;
            end else if (w_mem_rd) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_mem[r_rd_ptr];
            end else if (w_deq) begin
                r_out_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_param_fifo.sv
// Drives an FWFT and a registered-output FIFO with identical stimulus.
// Both are checked every cycle against a queue-based reference.
module tb_param_fifo;
    localparam int DW = 8, DEPTH = 4, AF_TH = 3, AE_TH = 1;

    logic clk, rst_n, flush;
    logic full_a, empty_a, af_a, ae_a, ov_a;
    logic full_b, empty_b, af_b, ae_b, ov_b;
    logic [2:0] cnt_a, mx_a, cnt_b, mx_b;

    param_fifo_if #(.DATA_W(DW)) ifa ();
    param_fifo_if #(.DATA_W(DW)) ifb ();

    param_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_fwft (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .flush(flush),
        .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(cnt_a), .max_count(mx_a), .overflow(ov_a));

    param_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_reg (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .flush(flush),
        .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .count(cnt_b), .max_count(mx_b), .overflow(ov_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, edge_n = 0;
    // Reference: index 0 = fall-through, 1 = registered output (one extra edge of latency).
    logic [7:0] mqd [2][$];
    int         mqe [2][$];
    int         mx_m [2];
    bit         ov_m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mvalid(input int m);
        if (mqd[m].size() == 0) return 1'b0;
        return edge_n >= mqe[m][0] + m;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mqd[m].delete();
            mqe[m].delete();
            mx_m[m] = 0;
            ov_m[m] = 1'b0;
        end
    endtask

    task automatic chk_dut(input int m, input logic [2:0] c, input logic [2:0] mc,
                           input logic fu, input logic em, input logic af, input logic ae,
                           input logic ov, input logic er, input logic dv, input logic [7:0] dd);
        int    n = mqd[m].size();
        string s = (m == 0) ? "fwft" : "reg";
        chk({s, "_count"}, 32'(c), 32'(n));
        chk({s, "_full"}, 32'(fu), 32'(n == DEPTH));
        chk({s, "_empty"}, 32'(em), 32'(n == 0));
        chk({s, "_afull"}, 32'(af), 32'(n >= AF_TH));
        chk({s, "_aempty"}, 32'(ae), 32'(n <= AE_TH));
        chk({s, "_enq_ready"}, 32'(er), 32'((n != DEPTH) && !flush));
        chk({s, "_deq_valid"}, 32'(dv), 32'(mvalid(m)));
        chk({s, "_max"}, 32'(mc), 32'(mx_m[m]));
        chk({s, "_ovf"}, 32'(ov), 32'(ov_m[m]));
        if (mvalid(m)) chk({s, "_data"}, 32'(dd), 32'(mqd[m][0]));
    endtask

    task automatic check_all();
        chk_dut(0, cnt_a, mx_a, full_a, empty_a, af_a, ae_a, ov_a, ifa.enq_ready, ifa.deq_valid, ifa.deq_data);
        chk_dut(1, cnt_b, mx_b, full_b, empty_b, af_b, ae_b, ov_b, ifb.enq_ready, ifb.deq_valid, ifb.deq_data);
    endtask

    task automatic cycle(input bit en, input logic [7:0] d, input bit rdy, input bit fl);
        bit ef [2];
        bit df [2];
        ifa.enq_valid = en; ifa.enq_data = d; ifa.deq_ready = rdy;
        ifb.enq_valid = en; ifb.enq_data = d; ifb.deq_ready = rdy;
        flush = fl;
        for (int m = 0; m < 2; m++) begin
            ef[m] = en && !fl && (mqd[m].size() < DEPTH);
            df[m] = rdy && !fl && mvalid(m);
            if (en && !fl && mqd[m].size() == DEPTH) ov_m[m] = 1'b1;
        end
        @(posedge clk);
        edge_n++;
        for (int m = 0; m < 2; m++) begin
            if (fl) begin
                mqd[m].delete();
                mqe[m].delete();
                mx_m[m] = 0;
                ov_m[m] = 1'b0;
            end else begin
                if (df[m]) begin
                    void'(mqd[m].pop_front());
                    void'(mqe[m].pop_front());
                end
                if (ef[m]) begin
                    mqd[m].push_back(d);
                    mqe[m].push_back(edge_n);
                end
                if (mqd[m].size() > mx_m[m]) mx_m[m] = mqd[m].size();
            end
        end
        #1;
        check_all();
    endtask

    logic [7:0] exp_order [4];

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        ifa.enq_valid = 1'b0; ifa.enq_data = '0; ifa.deq_ready = 1'b0;
        ifb.enq_valid = 1'b0; ifb.enq_data = '0; ifb.deq_ready = 1'b0;
        model_clear();
        #12;
        check_all();
        rst_n = 1'b1;

        // Fill to full with the consumer stalled, then one write too many.
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        chk("fill3_afull", 32'(af_a), 32'd1);
        cycle(1, 8'h44, 0, 0);
        chk("fill4_full", 32'(full_a), 32'd1);
        chk("fill4_enq_ready", 32'(ifa.enq_ready), 32'd0);
        cycle(1, 8'h55, 0, 0);
        chk("ovf_set_fwft", 32'(ov_a), 32'd1);
        chk("ovf_set_reg", 32'(ov_b), 32'd1);
        cycle(0, 8'h00, 0, 0);
        chk("ovf_hold", 32'(ov_a), 32'd1);

        exp_order[0] = 8'h11; exp_order[1] = 8'h22; exp_order[2] = 8'h33; exp_order[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(ifa.deq_data), 32'(exp_order[i]));
            cycle(0, 8'h00, 1, 0);
        end
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("drain_empty", 32'(empty_b), 32'd1);

        // Steady streaming at occupancy 2 across several pointer wraps.
        cycle(1, 8'h60, 0, 0);
        cycle(1, 8'h61, 0, 0);
        cycle(0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'h62 + i), 1, 0);
            chk("stream_cnt_fwft", 32'(cnt_a), 32'd2);
            chk("stream_cnt_reg", 32'(cnt_b), 32'd2);
        end
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);

        // Enqueue-to-valid latency of both output styles.
        cycle(1, 8'hA5, 0, 0);
        chk("lat_fwft", 32'(ifa.deq_valid), 32'd1);
        chk("lat_reg_early", 32'(ifb.deq_valid), 32'd0);
        cycle(0, 8'h00, 0, 0);
        chk("lat_reg", 32'(ifb.deq_valid), 32'd1);
        chk("lat_reg_data", 32'(ifb.deq_data), 32'hA5);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Flush with a competing write.
        cycle(1, 8'h31, 0, 0);
        cycle(1, 8'h32, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(1, 8'h99, 0, 1);
        chk("flush_cnt", 32'(cnt_a), 32'd0);
        chk("flush_empty", 32'(empty_b), 32'd1);
        chk("flush_max", 32'(mx_a), 32'd0);
        chk("flush_ovf", 32'(ov_a), 32'd0);
        cycle(1, 8'h12, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("post_flush_head", 32'(ifa.deq_data), 32'h12);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);

        // Asynchronous reset mid-stream at occupancy 2.
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h70, 0, 0);
        cycle(1, 8'h71, 0, 0);
        chk("pre_rst_cnt", 32'(cnt_a), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("async_rst_cnt", 32'(cnt_b), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cycle(1, 8'h77, 0, 0);
        chk("post_rst_head_fwft", 32'(ifa.deq_data), 32'h77);
        cycle(0, 8'h00, 0, 0);
        chk("post_rst_head_reg", 32'(ifb.deq_data), 32'h77);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
